// File: rtl/ifetch_prefetch_buffer.sv
// Instruction prefetch buffer: streams words from synchronous-read instruction memory
// into a DEPTH-entry PC-tagged FIFO drained by valid/ready; flush restarts fetch.
module ifetch_prefetch_buffer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     flush,
    input  logic [ADDR_W-1:0]        flush_addr,
    output logic                     mem_rd,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [DATA_W-1:0]        mem_data,
    output logic [DATA_W-1:0]        ins_out,
    output logic [ADDR_W-1:0]        ins_pc,
    output logic                     ins_valid,
    input  logic                     ins_ready,
    output logic [$clog2(DEPTH):0]   count
);

    // Handshake: a head entry transfers on a rising edge where ins_valid and
    // ins_ready are both high and flush is low; ins_valid never waits on ready.
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              inflight_q, inflight_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];

    logic [OCC_W-1:0]  occupancy;
    logic              can_issue;
    logic              push;
    logic              pop;

    always_comb begin
        // Credit counts the in-flight read; a same-cycle pop frees nothing yet.
        occupancy = OCC_W'(count_q) + OCC_W'(inflight_q);
        can_issue = en & ~flush & (occupancy < OCC_W'(DEPTH));
        mem_rd    = rst_n & can_issue;
        mem_addr  = pc_q;
        ins_valid = (count_q != '0);
        ins_out   = ins_valid ? data_mem[rd_ptr_q] : '0;
        ins_pc    = ins_valid ? pc_mem[rd_ptr_q]   : '0;
        count     = count_q;
        push      = inflight_q & ~flush;
        pop       = ins_valid & ins_ready & ~flush;
    end

    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = inflight_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (flush) begin
            pc_d       = flush_addr;
            inflight_d = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            inflight_d = can_issue;
            if (can_issue) begin
                pc_d     = pc_q + ADDR_W'(1);
                req_pc_d = pc_q;
            end
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= '0;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage is deliberately left out of reset; count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= mem_data;
            pc_mem[wr_ptr_q]   <= req_pc_q;
        end
    end

endmodule

// File: tb/tb_ifetch_prefetch_buffer.sv
// Bench for ifetch_prefetch_buffer: instruction memory model, queue-based reference
// model of the buffer contents, and directed plus random scenarios.
module tb_ifetch_prefetch_buffer;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          flush = 1'b0;
    logic [AW-1:0] flush_addr = '0;
    logic          ins_ready = 1'b0;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data = '0;
    logic [DW-1:0] ins_out;
    logic [AW-1:0] ins_pc;
    logic          ins_valid;
    logic [2:0]    count;

    logic [DW-1:0] mem [256];

    logic [DW+AW-1:0] exp_q[$];
    bit               m_inflight;
    logic [AW-1:0]    m_req_pc;
    logic [AW-1:0]    m_pc;
    logic [AW-1:0]    stream_pc;
    int               n_checks = 0;
    int               n_fail = 0;

    ifetch_prefetch_buffer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .flush_addr(flush_addr),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
        .ins_out(ins_out), .ins_pc(ins_pc), .ins_valid(ins_valid),
        .ins_ready(ins_ready), .count(count)
    );

    always #5 clk = ~clk;

    // Synchronous-read instruction memory.
    always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

    task automatic model_clear();
        exp_q.delete();
        m_inflight = 1'b0;
        m_req_pc   = '0;
        m_pc       = '0;
        stream_pc  = '0;
    endtask

    // One clock of scoreboard: compare outputs, then advance the model over the edge.
    task automatic cycle();
        logic             exp_rd;
        logic             do_pop;
        logic [DW+AW-1:0] head;
        #1;
        exp_rd = en && !flush && ((exp_q.size() + int'(m_inflight)) < DEPTH);
        n_checks++;
        if (mem_rd !== exp_rd) begin
            n_fail++; $display("FAIL mem_rd: got %b expected %b at %0t", mem_rd, exp_rd, $time);
        end
        if (exp_rd) begin
            n_checks++;
            if (mem_addr !== m_pc) begin
                n_fail++; $display("FAIL mem_addr: got %h expected %h at %0t", mem_addr, m_pc, $time);
            end
        end
        n_checks++;
        if ($isunknown(count) || int'(count) != exp_q.size()) begin
            n_fail++; $display("FAIL count: got %0d expected %0d at %0t", count, exp_q.size(), $time);
        end
        n_checks++;
        if (ins_valid !== (exp_q.size() != 0)) begin
            n_fail++; $display("FAIL ins_valid: got %b expected %b at %0t", ins_valid, exp_q.size() != 0, $time);
        end
        head = (exp_q.size() != 0) ? exp_q[0] : '0;
        n_checks++;
        if ({ins_out, ins_pc} !== head) begin
            n_fail++; $display("FAIL head: got %h/%h expected %h/%h at %0t", ins_out, ins_pc, head[DW+AW-1:AW], head[AW-1:0], $time);
        end
        do_pop = (exp_q.size() != 0) && ins_ready && !flush;
        if (do_pop) begin
            n_checks++;
            if (ins_pc !== stream_pc || ins_out !== mem[stream_pc]) begin
                n_fail++; $display("FAIL stream: got %h@%h expected %h@%h at %0t", ins_out, ins_pc, mem[stream_pc], stream_pc, $time);
            end
            stream_pc = stream_pc + 1'b1;
        end
        @(posedge clk);
        if (flush) begin
            exp_q.delete();
            m_inflight = 1'b0;
            m_pc       = flush_addr;
            stream_pc  = flush_addr;
        end else begin
            if (do_pop) void'(exp_q.pop_front());
            if (m_inflight) exp_q.push_back({mem[m_req_pc], m_req_pc});
            m_inflight = exp_rd;
            if (exp_rd) begin
                m_req_pc = m_pc;
                m_pc     = m_pc + 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        en = 1'b1;
        ins_ready = 1'b1;
        #1;
        n_checks++;
        if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rd: got %b expected 0", mem_rd); end
        n_checks++;
        if (ins_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", ins_valid); end
        n_checks++;
        if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++;
        if (ins_out !== 8'h00 || ins_pc !== 8'h00) begin
            n_fail++; $display("FAIL reset_head: got %h/%h expected 00/00", ins_out, ins_pc);
        end
        n_checks++;
        if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %h expected 00", mem_addr); end
    endtask

    task automatic test_stream();
        logic [7:0] e;
        do_reset();
        en = 1'b1;
        ins_ready = 1'b1;
        cycle();
        cycle();
        for (int k = 0; k < 8; k++) begin
            e = 8'h10 + 8'(k);
            n_checks++;
            if (ins_valid !== 1'b1 || ins_out !== e || ins_pc !== 8'(k)) begin
                n_fail++; $display("FAIL stream_seq: got v=%b %h@%h expected v=1 %h@%h", ins_valid, ins_out, ins_pc, e, 8'(k));
            end
            cycle();
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] e;
        do_reset();
        en = 1'b1;
        ins_ready = 1'b0;
        repeat (8) cycle();
        #1;
        n_checks++;
        if (count !== 3'd4) begin n_fail++; $display("FAIL bp_count: got %0d expected 4", count); end
        n_checks++;
        if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL bp_mem_rd: got %b expected 0", mem_rd); end
        n_checks++;
        if (ins_out !== 8'h10 || ins_pc !== 8'h00) begin
            n_fail++; $display("FAIL bp_head: got %h@%h expected 10@00", ins_out, ins_pc);
        end
        ins_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            e = 8'h10 + 8'(k);
            n_checks++;
            if (ins_out !== e || ins_pc !== 8'(k)) begin
                n_fail++; $display("FAIL bp_drain: got %h@%h expected %h@%h", ins_out, ins_pc, e, 8'(k));
            end
            cycle();
        end
    endtask

    task automatic flush_and_follow(input logic [7:0] addr, input string name);
        int w;
        logic [7:0] p;
        flush = 1'b1;
        flush_addr = addr;
        cycle();
        flush = 1'b0;
        n_checks++;
        if (ins_valid !== 1'b0) begin n_fail++; $display("FAIL %s_drop: got valid %b expected 0", name, ins_valid); end
        w = 0;
        while (ins_valid !== 1'b1 && w < 6) begin
            cycle();
            w++;
        end
        n_checks++;
        if (w != 2) begin n_fail++; $display("FAIL %s_latency: got %0d cycles expected 2", name, w); end
        for (int k = 0; k < 4; k++) begin
            p = addr + 8'(k);
            n_checks++;
            if (ins_pc !== p || ins_out !== mem[p]) begin
                n_fail++; $display("FAIL %s_seq: got %h@%h expected %h@%h", name, ins_out, ins_pc, mem[p], p);
            end
            cycle();
        end
    endtask

    task automatic test_flush();
        do_reset();
        en = 1'b1;
        ins_ready = 1'b1;
        repeat (5) cycle();
        flush_and_follow(8'h40, "flush");
    endtask

    task automatic test_wrap();
        en = 1'b1;
        ins_ready = 1'b1;
        repeat (3) cycle();
        flush_and_follow(8'hFE, "wrap");
    endtask

    task automatic test_random();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            en         = ($urandom_range(0, 3) != 0);
            ins_ready  = ($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 39) == 0);
            flush_addr = 8'($urandom);
            cycle();
        end
        flush = 1'b0;
    endtask

    task automatic test_reset_mid();
        int w;
        do_reset();
        en = 1'b1;
        ins_ready = 1'b0;
        w = 0;
        while (count !== 3'd3 && w < 10) begin
            cycle();
            w++;
        end
        n_checks++;
        if (count !== 3'd3) begin n_fail++; $display("FAIL mid_fill: got %0d expected 3", count); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ins_valid !== 1'b0 || count !== 3'd0) begin
            n_fail++; $display("FAIL mid_reset_state: got v=%b cnt=%0d expected v=0 cnt=0", ins_valid, count);
        end
        n_checks++;
        if (mem_rd !== 1'b0 || ins_out !== 8'h00 || ins_pc !== 8'h00 || mem_addr !== 8'h00) begin
            n_fail++; $display("FAIL mid_reset_outs: got rd=%b %h@%h addr=%h expected 0 00@00 00", mem_rd, ins_out, ins_pc, mem_addr);
        end
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        ins_ready = 1'b1;
        repeat (8) cycle();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i + 16);
        model_clear();
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
